// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, selects next PC (stall > jump > branch > PC+4),
// halts when fetch leaves the memory image. Optional FETCH_MISALIGN_CHECK_EN faults on misaligned redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] instr_i,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        halted_o,
  output logic [31:0] fetch_cnt_o,
  output logic        fault_o
);

  // 33-bit limit so PC+4 can never wrap back into range
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_p0;
  logic [31:0] cnt_p0;
  logic        redir;
  logic [31:0] raw_tgt;
  logic [32:0] cand;
  logic        out_of_range;
  logic        bad_align;
  logic        advance;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  always_comb begin
    redir   = 1'b0;
    raw_tgt = 32'h0;
    if (jump_i) begin
      redir   = 1'b1;
      raw_tgt = jump_target_i;
    end else if (branch_taken_i) begin
      redir   = 1'b1;
      raw_tgt = branch_target_i;
    end
    cand = redir ? {1'b0, raw_tgt & ~32'h3} : ({1'b0, pc_p0} + 33'd4);
    out_of_range = (cand >= IMEM_LIMIT);
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad_align = redir & (raw_tgt[1:0] != 2'b00);
`else
  assign bad_align = 1'b0;
`endif

  assign advance = (state == RUN) & ~stall_i & ~out_of_range & ~bad_align;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= HOLD;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      HOLD:    state_nxt = RUN;
      RUN:     if (!stall_i && (out_of_range || bad_align)) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = HOLD;
    endcase
  end

  // PC and retired-fetch counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_p0  <= RESET_PC;
      cnt_p0 <= 32'h0;
    end else if (advance) begin
      pc_p0  <= cand[31:0];
      cnt_p0 <= sat_inc(cnt_p0);
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_p0;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                          fault_p0 <= 1'b0;
    else if ((state == RUN) && !stall_i && bad_align)    fault_p0 <= 1'b1;
  end
  assign fault_o = fault_p0;
`else
  assign fault_o = 1'b0;
`endif

  // Outputs
  always_comb begin
    imem_addr_o   = pc_p0;
    pc_plus4_o    = pc_p0 + 32'd4;
    fetch_cnt_o   = cnt_p0;
    instr_o       = (state == RUN) ? instr_i : 32'h0;
    instr_valid_o = (state == RUN) & ~stall_i;
    halted_o      = (state == HALT);
  end

endmodule
